// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the pipeline and the data bus.
// Aligns store data and byte strobes, extracts and extends load data, traps misaligned ops.
module mem_access_unit #(
  parameter int XLEN           = 64,
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_write,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic              flush,
  output logic              dreq_valid,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [XLEN/8-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_misalign
);

  // state | meaning
  // IDLE  | waiting for an op; only state that accepts
  // REQ   | bus request outstanding
  // DONE  | result (or alignment trap) presented until consumed or flushed
  // DRAIN | flushed while on the bus; wait out the response and drop it
  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

  localparam int SW   = XLEN / 8;
  localparam int OFFW = $clog2(SW);
  localparam logic [XLEN-1:0] ONES = '1;

  state_t state, next_state;

  logic            op_write, op_unsigned, op_misalign;
  logic [1:0]      op_size;
  logic [XLEN-1:0] op_addr, op_wdata, rdata_q;

  logic            accept, capture, misalign_in;
  logic [2:0]      align_mask;
  logic [OFFW-1:0] offset;

  always_comb begin
    align_mask = 3'b000;
    unique case (in_size)
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      2'd3:    align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
  end

  assign misalign_in = MISALIGN_CHECK && (|(in_addr[2:0] & align_mask));
  assign accept      = (state == IDLE) && in_valid && !flush;
  assign capture     = (state == REQ) && dresp_data_ok && !flush;
  assign offset      = op_addr[OFFW-1:0];

  // Store path: byte-count mask shifted into lane position, upper overflow dropped.
  logic [3:0]      byte_cnt;
  logic [SW-1:0]   size_mask;
  logic [2*SW-1:0] strobe_wide;

  assign byte_cnt    = 4'd1 << op_size;
  assign size_mask   = ~({SW{1'b1}} << byte_cnt);
  assign strobe_wide = {{SW{1'b0}}, size_mask} << offset;

  assign dreq_addr   = op_addr;
  assign dreq_size   = {1'b0, op_size};
  assign dreq_strobe = op_write ? strobe_wide[SW-1:0] : '0;
  assign dreq_data   = op_wdata << {offset, 3'b000};

  // Load path: right-align the addressed bytes, keep size bytes, extend the rest.
  logic [XLEN-1:0] ld_shift, ld_keep, ld_ext;
  logic            ld_sign;

  assign ld_shift = dresp_data >> {offset, 3'b000};

  always_comb begin
    ld_keep = ONES;
    ld_sign = ld_shift[XLEN-1];
    unique case (op_size)
      2'd0:    begin ld_keep = ~(ONES << 8);  ld_sign = ld_shift[7];  end
      2'd1:    begin ld_keep = ~(ONES << 16); ld_sign = ld_shift[15]; end
      2'd2:    begin ld_keep = ~(ONES << 32); ld_sign = ld_shift[31]; end
      default: begin ld_keep = ONES;          ld_sign = ld_shift[XLEN-1]; end
    endcase
    ld_ext = (ld_shift & ld_keep) | (~ld_keep & {XLEN{ld_sign & ~op_unsigned}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    dreq_valid = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) next_state = misalign_in ? DONE : REQ;
      end
      REQ: begin
        dreq_valid = 1'b1;
        if (flush)              next_state = dresp_data_ok ? IDLE : DRAIN;
        else if (dresp_data_ok) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) next_state = IDLE;
      end
      DRAIN: begin
        dreq_valid = 1'b1;
        if (dresp_data_ok) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_write    <= 1'b0;
      op_unsigned <= 1'b0;
      op_misalign <= 1'b0;
      op_size     <= '0;
      op_addr     <= '0;
      op_wdata    <= '0;
      rdata_q     <= '0;
    end else if (accept) begin
      op_write    <= in_write;
      op_unsigned <= in_unsigned;
      op_misalign <= misalign_in;
      op_size     <= in_size;
      op_addr     <= in_addr;
      op_wdata    <= in_wdata;
      rdata_q     <= '0;
    end else if (capture) begin
      rdata_q <= op_write ? '0 : ld_ext;
    end
  end

  assign out_rdata    = rdata_q;
  assign out_misalign = op_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected results to a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_mem_access_unit;

  logic        clk, reset;
  logic        in_valid, in_write, in_unsigned, flush;
  logic [1:0]  in_size;
  logic [63:0] in_addr, in_wdata;
  logic        dresp_data_ok, out_ready;
  logic [63:0] dresp_data;

  logic        in_ready, dreq_valid, out_valid, out_misalign;
  logic [63:0] dreq_addr, dreq_data, out_rdata;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;

  logic        nc_in_ready, nc_dreq_valid, nc_out_valid, nc_out_misalign;
  logic [63:0] nc_dreq_addr, nc_dreq_data, nc_out_rdata;
  logic [2:0]  nc_dreq_size;
  logic [7:0]  nc_dreq_strobe;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        mis;
  } exp_t;
  exp_t exp_q[$];

  mem_access_unit #(.XLEN(64), .MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_misalign(out_misalign)
  );

  mem_access_unit #(.XLEN(64), .MISALIGN_CHECK(1'b0)) dut_nc (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(nc_in_ready), .in_write(in_write), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
    .dreq_valid(nc_dreq_valid), .dreq_addr(nc_dreq_addr), .dreq_size(nc_dreq_size),
    .dreq_strobe(nc_dreq_strobe), .dreq_data(nc_dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_rdata(nc_out_rdata),
    .out_misalign(nc_out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got out_valid with rdata 0x%0h, expected no result", out_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("out_rdata", out_rdata, e.rdata);
        chk("out_misalign", {63'b0, out_misalign}, {63'b0, e.mis});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] rdata, input logic mis);
    exp_t e;
    e.rdata = rdata;
    e.mis   = mis;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    chk("in_ready_idle", {63'b0, in_ready}, 64'd1);
    in_valid    = 1'b1;
    in_write    = wr;
    in_size     = sz;
    in_unsigned = uns;
    in_addr     = addr;
    in_wdata    = wdata;
    cyc();
    in_valid = 1'b0;
    in_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
    in_wdata = 64'h5555_5555_5555_5555;
  endtask

  task automatic respond(input string name, input int waits, input logic [63:0] addr,
                         input logic [1:0] sz, input logic [63:0] bus_data,
                         input logic [7:0] strobe, input logic [63:0] data);
    for (int i = 0; i <= waits; i++) begin
      chk({name, "_dreq_valid"}, {63'b0, dreq_valid}, 64'd1);
      chk({name, "_dreq_addr"}, dreq_addr, addr);
      chk({name, "_dreq_size"}, {61'b0, dreq_size}, {62'b0, sz});
      chk({name, "_dreq_strobe"}, {56'b0, dreq_strobe}, {56'b0, strobe});
      chk({name, "_dreq_data"}, dreq_data, data);
      if (i == waits) begin
        dresp_data_ok = 1'b1;
        dresp_data    = bus_data;
      end else begin
        dresp_data = 64'hDEAD_BEEF_CAFE_F00D;
      end
      cyc();
    end
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h0;
  endtask

  task automatic run_op(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] bus_data,
                        input logic [7:0] strobe, input logic [63:0] data,
                        input logic [63:0] rdata, input int waits);
    push_exp(rdata, 1'b0);
    issue(wr, sz, uns, addr, wdata);
    respond(name, waits, addr, sz, bus_data, strobe, data);
    chk({name, "_out_valid"}, {63'b0, out_valid}, 64'd1);
    chk({name, "_dreq_idle_done"}, {63'b0, dreq_valid}, 64'd0);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_write = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0; flush = 1'b0;
    dresp_data_ok = 1'b0; dresp_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_rdata", out_rdata, 64'd0);
    chk("rst_out_misalign", {63'b0, out_misalign}, 64'd0);
    cyc();

    // Byte 3 of 0x0000_0000_8000_0000 is 0x80, byte 4 is 0x00.
    run_op("ld_b_s_1003", 1'b0, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0);
    run_op("ld_b_s_1004", 1'b0, 2'd0, 1'b0, 64'h1004, 64'h0, 64'h0000_0000_8000_0000,
           8'h00, 64'h0, 64'h0, 0);
    run_op("ld_b_u_1003", 1'b0, 2'd0, 1'b1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000,
           8'h00, 64'h0, 64'h80, 0);
    run_op("st_h_2006", 1'b1, 2'd1, 1'b0, 64'h2006, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF,
           8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 5);
    run_op("ld_w_s_3004", 1'b0, 2'd2, 1'b0, 64'h3004, 64'h0, 64'h8765_4321_0000_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 0);
    run_op("ld_h_u_300a", 1'b0, 2'd1, 1'b1, 64'h300A, 64'h0, 64'h0000_0000_F00D_0000,
           8'h00, 64'h0, 64'hF00D, 2);
    run_op("ld_d_3008", 1'b0, 2'd3, 1'b0, 64'h3008, 64'h0, 64'h0123_4567_89AB_CDEF,
           8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1);
    run_op("st_b_4001", 1'b1, 2'd0, 1'b0, 64'h4001, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0,
           8'h02, 64'hFFFF_FFFF_FFFF_5A00, 64'h0, 0);
    run_op("st_w_4004", 1'b1, 2'd2, 1'b0, 64'h4004, 64'h1122_3344, 64'h0,
           8'hF0, 64'h1122_3344_0000_0000, 64'h0, 0);
    run_op("st_d_4000", 1'b1, 2'd3, 1'b0, 64'h4000, 64'h0102_0304_0506_0708, 64'h0,
           8'hFF, 64'h0102_0304_0506_0708, 64'h0, 0);

    // Misaligned word load: trapping instance goes straight to DONE, the other issues it.
    push_exp(64'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 64'h3002, 64'h0);
    chk("mis_out_valid", {63'b0, out_valid}, 64'd1);
    chk("mis_out_misalign", {63'b0, out_misalign}, 64'd1);
    chk("mis_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    chk("nc_dreq_valid", {63'b0, nc_dreq_valid}, 64'd1);
    chk("nc_dreq_addr", nc_dreq_addr, 64'h3002);
    chk("nc_dreq_size", {61'b0, nc_dreq_size}, 64'd2);
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h1111_2222_8765_4321;
    cyc();
    dresp_data_ok = 1'b0;
    chk("mis_back_idle", {63'b0, in_ready}, 64'd1);
    chk("nc_out_valid", {63'b0, nc_out_valid}, 64'd1);
    chk("nc_out_rdata", nc_out_rdata, 64'h2222_8765);
    chk("nc_out_misalign", {63'b0, nc_out_misalign}, 64'd0);
    cyc();

    // Flush in IDLE suppresses acceptance.
    in_valid = 1'b1; in_write = 1'b0; in_size = 2'd0; in_addr = 64'h10; flush = 1'b1;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_dreq", {63'b0, dreq_valid}, 64'd0);
    chk("flush_idle_in_ready", {63'b0, in_ready}, 64'd1);

    // Flush in REQ: bus op drains, no result.
    issue(1'b0, 2'd3, 1'b0, 64'h8000, 64'h0);
    chk("drain_c1_dreq", {63'b0, dreq_valid}, 64'd1);
    cyc();
    chk("drain_c2_dreq", {63'b0, dreq_valid}, 64'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("drain_c3_dreq", {63'b0, dreq_valid}, 64'd1);
    chk("drain_c3_addr", dreq_addr, 64'h8000);
    cyc();
    chk("drain_c4_dreq", {63'b0, dreq_valid}, 64'd1);
    chk("drain_c4_in_ready", {63'b0, in_ready}, 64'd0);
    flush = 1'b1;
    dresp_data_ok = 1'b1; dresp_data = 64'h1234;
    cyc();
    flush = 1'b0; dresp_data_ok = 1'b0;
    chk("drain_c5_in_ready", {63'b0, in_ready}, 64'd1);
    chk("drain_c5_out_valid", {63'b0, out_valid}, 64'd0);
    chk("drain_c5_dreq", {63'b0, dreq_valid}, 64'd0);

    // Flush in REQ together with data_ok returns directly to IDLE.
    issue(1'b0, 2'd0, 1'b0, 64'h8001, 64'h0);
    flush = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'hFF00;
    cyc();
    flush = 1'b0; dresp_data_ok = 1'b0;
    chk("flush_ok_in_ready", {63'b0, in_ready}, 64'd1);
    chk("flush_ok_out_valid", {63'b0, out_valid}, 64'd0);

    // Back-pressure in DONE.
    out_ready = 1'b0;
    push_exp(64'hFFFF_FFFF_FFFF_8001, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 64'h5000, 64'h0);
    respond("bp", 0, 64'h5000, 2'd1, 64'h0000_0000_0000_8001, 8'h00, 64'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_out_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_8001);
      chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
      if (i < 2) cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_release_in_ready", {63'b0, in_ready}, 64'd1);
    chk("bp_release_out_valid", {63'b0, out_valid}, 64'd0);

    // Flush in DONE drops the result.
    out_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b1, 64'h6004, 64'h0);
    respond("fdone", 0, 64'h6004, 2'd2, 64'hAAAA_BBBB_0000_0000, 8'h00, 64'h0);
    chk("fdone_out_valid", {63'b0, out_valid}, 64'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0; out_ready = 1'b1;
    chk("fdone_dropped", {63'b0, out_valid}, 64'd0);
    chk("fdone_in_ready", {63'b0, in_ready}, 64'd1);

    // Flush with out_ready in DONE counts as consumed.
    push_exp(64'h0BAD_F00D_1234_5678, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 64'h6000, 64'h0);
    respond("fcons", 0, 64'h6000, 2'd3, 64'h0BAD_F00D_1234_5678, 8'h00, 64'h0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fcons_in_ready", {63'b0, in_ready}, 64'd1);

    // Reset in REQ abandons the op; a late data_ok is ignored.
    issue(1'b0, 2'd3, 1'b0, 64'h7000, 64'h0);
    chk("rreq_dreq_before", {63'b0, dreq_valid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("rreq_dreq_async", {63'b0, dreq_valid}, 64'd0);
    chk("rreq_out_rdata", out_rdata, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dresp_data_ok = 1'b1; dresp_data = 64'h7777;
    cyc();
    dresp_data_ok = 1'b0;
    chk("rreq_late_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rreq_late_dreq", {63'b0, dreq_valid}, 64'd0);
    chk("rreq_in_ready", {63'b0, in_ready}, 64'd1);
    cyc();
    chk("rreq_still_idle", {63'b0, out_valid}, 64'd0);

    cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
